// File: rtl/solar_disp_pkg.sv
// Shared channel codes, FSM encoding and helpers for the display scan sequencer.
package solar_disp_pkg;

  localparam int NUM_CH = 5;

  localparam logic [2:0] CH_VOLT = 3'd0;
  localparam logic [2:0] CH_CURR = 3'd1;
  localparam logic [2:0] CH_PWR  = 3'd2;
  localparam logic [2:0] CH_TEMP = 3'd3;
  localparam logic [2:0] CH_EFF  = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SHOW   = 2'd2;

  // Out-of-range manual requests fall back to the voltage channel.
  function automatic logic [2:0] clamp_ch(input logic [2:0] ch);
    return (ch > CH_EFF) ? CH_VOLT : ch;
  endfunction

endpackage

// File: rtl/disp_next_ch.sv
// Circular search for the next unmasked channel after cur_ch_i.
module disp_next_ch
  import solar_disp_pkg::*;
(
  input  logic [2:0]        cur_ch_i,
  input  logic [NUM_CH-1:0] skip_mask_i,
  output logic [2:0]        next_ch_o,
  output logic              wrap_o,
  output logic              all_masked_o
);

  always_comb begin : search
    logic       found;
    logic [2:0] idx;
    found     = 1'b0;
    idx       = 3'd0;
    next_ch_o = cur_ch_i;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = 3'((int'(cur_ch_i) + k) % NUM_CH);
      if (!found && !skip_mask_i[idx]) begin
        next_ch_o = idx;
        found     = 1'b1;
      end
    end
    all_masked_o = &skip_mask_i;
    // A lone unmasked channel maps onto itself and still counts as a wrap.
    wrap_o = !all_masked_o && (next_ch_o <= cur_ch_i);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Drives the registered 5-to-1 display mux select and captures its output once settled.
module display_scan_ctrl
  import solar_disp_pkg::*;
#(
  parameter int DATA_W        = 12,
  parameter int SETTLE_CYCLES = 2,
  parameter int DWELL_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              manual,
  input  logic [2:0]        manual_sel,
  input  logic [NUM_CH-1:0] skip_mask,
  input  logic              hold,
  input  logic [DATA_W-1:0] mux_data,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] disp_data,
  output logic [2:0]        disp_ch,
  output logic              disp_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              frame_q, frame_d;
  logic              busy_q;

  logic [2:0] nxt_ch, start_ch, man_ch;
  logic       nxt_wrap, nxt_all_masked;
  logic       start_wrap, start_all_masked;
  logic       unused_start_wrap;

  disp_next_ch u_next (
    .cur_ch_i     (sel_q),
    .skip_mask_i  (skip_mask),
    .next_ch_o    (nxt_ch),
    .wrap_o       (nxt_wrap),
    .all_masked_o (nxt_all_masked)
  );

  // Searching onward from the last channel yields the lowest unmasked one.
  disp_next_ch u_start (
    .cur_ch_i     (CH_EFF),
    .skip_mask_i  (skip_mask),
    .next_ch_o    (start_ch),
    .wrap_o       (start_wrap),
    .all_masked_o (start_all_masked)
  );

  assign unused_start_wrap = start_wrap;
  assign man_ch            = clamp_ch(manual_sel);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    frame_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (manual) begin
            sel_d   = man_ch;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else if (!start_all_masked) begin
            sel_d   = start_ch;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            data_d  = mux_data;
            ch_d    = sel_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (manual && (man_ch != sel_q)) begin
            sel_d   = man_ch;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else if (!hold) begin
            if (cnt_q == DWELL_LAST) begin
              cnt_d = '0;
              if (manual) begin
                sel_d   = man_ch;
                state_d = ST_SETTLE;
              end else if (nxt_all_masked) begin
                state_d = ST_IDLE;
              end else begin
                sel_d   = nxt_ch;
                frame_d = nxt_wrap;
                state_d = ST_SETTLE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign sel         = sel_q;
  assign disp_data   = data_q;
  assign disp_ch     = ch_q;
  assign disp_valid  = valid_q;
  assign frame_start = frame_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a registered mux model and capture scoreboard.
module tb_display_scan_ctrl;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst, enable, manual, hold;
  logic [2:0]  manual_sel;
  logic [4:0]  skip_mask;
  logic [11:0] mux_data = 12'h000;
  logic [2:0]  sel, disp_ch;
  logic [11:0] disp_data;
  logic        disp_valid, frame_start, busy;

  int   n_pass = 0;
  int   n_total = 0;
  int   vcnt = 0;
  int   vsnap;
  cap_t sb[$];

  display_scan_ctrl #(.DATA_W(12), .SETTLE_CYCLES(2), .DWELL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .manual(manual),
    .manual_sel(manual_sel), .skip_mask(skip_mask), .hold(hold),
    .mux_data(mux_data), .sel(sel), .disp_data(disp_data),
    .disp_ch(disp_ch), .disp_valid(disp_valid),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered mux: one cycle from sel to data, as in mux_5to1.
  always @(posedge clk) mux_data <= 12'h100 + 12'(sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] ch);
    cap_t e;
    e.ch   = ch;
    e.data = 12'h100 + 12'(ch);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && disp_valid) begin
      cap_t e;
      vcnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'(disp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ch", 32'(disp_ch), 32'(e.ch));
        chk("sb_data", 32'(disp_data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq2[3];
    seq2 = '{2, 4, 0};
    rst = 1'b1; enable = 1'b0; manual = 1'b0; manual_sel = 3'd0;
    skip_mask = 5'b0; hold = 1'b0;
    step(2);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_data", 32'(disp_data), 0);
    chk("rst_ch", 32'(disp_ch), 0);
    chk("rst_valid", 32'(disp_valid), 0);
    chk("rst_frame", 32'(frame_start), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: full auto rotation
    rst = 1'b0; enable = 1'b1;
    push(0); push(1); push(2); push(3); push(4); push(0);
    step(1);
    chk("t1_sel0", 32'(sel), 0);
    chk("t1_busy", 32'(busy), 1);
    step(2);
    chk("t1_valid_hi", 32'(disp_valid), 1);
    step(1);
    chk("t1_valid_lo", 32'(disp_valid), 0);
    step(3);
    chk("t1_sel1", 32'(sel), 1);
    chk("t1_frame1", 32'(frame_start), 0);
    for (int k = 2; k <= 5; k++) begin
      step(6);
      chk("t1_sel", 32'(sel), 32'(k % 5));
      chk("t1_frame", 32'(frame_start), 32'(k == 5));
    end
    step(5);
    enable = 1'b0;  // coincides with dwell expiry
    step(1);
    chk("t1_en_wins_sel", 32'(sel), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_drain", 32'(sb.size()), 0);

    // 2: masked channels, then everything masked
    skip_mask = 5'b01010; enable = 1'b1;
    push(0); push(2); push(4); push(0);
    step(1);
    chk("t2_sel0", 32'(sel), 0);
    for (int k = 1; k <= 3; k++) begin
      step(6);
      chk("t2_sel", 32'(sel), 32'(seq2[k-1]));
      chk("t2_frame", 32'(frame_start), 32'(k == 3));
    end
    step(3);
    enable = 1'b0;
    step(1);
    chk("t2_drain", 32'(sb.size()), 0);
    skip_mask = 5'b11111; enable = 1'b1; vsnap = vcnt;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t2_allmask_busy", 32'(busy), 0);
    end
    chk("t2_allmask_sel", 32'(sel), 0);
    chk("t2_allmask_novalid", 32'(vcnt), 32'(vsnap));
    enable = 1'b0;

    // 3: manual mode, refresh, override, clamp
    skip_mask = 5'b0; manual = 1'b1; manual_sel = 3'd3; enable = 1'b1;
    push(3); push(3);
    step(1);
    chk("t3_sel3", 32'(sel), 3);
    step(6);
    chk("t3_refresh_sel", 32'(sel), 3);
    step(2);
    chk("t3_refresh_valid", 32'(disp_valid), 1);
    step(1);
    manual_sel = 3'd1; push(1);
    step(1);
    chk("t3_override_sel", 32'(sel), 1);
    step(1);
    chk("t3_override_v0", 32'(disp_valid), 0);
    step(1);
    chk("t3_override_v1", 32'(disp_valid), 1);
    manual_sel = 3'd6; push(0);
    step(1);
    chk("t3_clamp_sel", 32'(sel), 0);
    step(2);
    chk("t3_clamp_valid", 32'(disp_valid), 1);
    step(1);
    enable = 1'b0; manual = 1'b0; manual_sel = 3'd0;
    step(1);
    chk("t3_drain", 32'(sb.size()), 0);

    // 4: hold in SETTLE has no effect, hold in SHOW stretches dwell
    enable = 1'b1; push(0); push(1);
    step(1);
    hold = 1'b1;
    step(2);
    chk("t4_settle_hold_valid", 32'(disp_valid), 1);
    hold = 1'b0;
    step(1);
    hold = 1'b1;
    step(10);
    hold = 1'b0;
    step(2);
    chk("t4_sel_before", 32'(sel), 0);
    step(1);
    chk("t4_sel_after", 32'(sel), 1);
    step(2);
    chk("t4_valid", 32'(disp_valid), 1);
    step(1);
    enable = 1'b0;
    step(1);
    chk("t4_drain", 32'(sb.size()), 0);

    // 5: abort in SETTLE, restart at lowest unmasked
    enable = 1'b1;
    step(1);
    chk("t5_sel0", 32'(sel), 0);
    enable = 1'b0; vsnap = vcnt;
    step(1);
    chk("t5_abort_busy", 32'(busy), 0);
    step(3);
    chk("t5_novalid", 32'(vcnt), 32'(vsnap));
    chk("t5_keep_data", 32'(disp_data), 32'h101);
    chk("t5_keep_ch", 32'(disp_ch), 1);
    skip_mask = 5'b00011; enable = 1'b1; push(2);
    step(1);
    chk("t5_restart_sel", 32'(sel), 2);
    step(3);

    // 6: asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("t6_sel", 32'(sel), 0);
    chk("t6_data", 32'(disp_data), 0);
    chk("t6_ch", 32'(disp_ch), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(disp_valid), 0);
    chk("t6_frame", 32'(frame_start), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; skip_mask = 5'b0; push(0);
    step(1);
    chk("t6_exit_busy", 32'(busy), 1);
    chk("t6_exit_valid", 32'(disp_valid), 0);
    step(1);
    chk("t6_v_early", 32'(disp_valid), 0);
    step(1);
    chk("t6_v_capture", 32'(disp_valid), 1);
    step(2);
    chk("t6_drain", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
